unidade_controle: RTL and testbench

Multi-cycle control unit sitting directly upstream of `datapath`. It owns the program counter sequence and drives every `datapath` control input. It reads the fetched instruction back on `saida_IR`, decodes the RV64 subset `ld`, `sd`, `add`, `sub` and `addi`, and steps each instruction through fetch, decode, execute and memory phases. Any other encoding halts the unit until reset.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/decodificador_instrucao.sv | 53 +++++
 rtl/unidade_controle.sv | 159 +++++++++++++++
 tb/tb_unidade_controle.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle control unit: opcode/funct constants,
// FSM state enumeration, decoded instruction classes and the default memory depth.
package riscv_pkg;

  localparam int IMEM_WORDS_DEF = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  localparam logic [2:0] F3_DOUBLE = 3'b011;
  localparam logic [2:0] F3_ADD    = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC,
    ST_BUSCA,
    ST_IR,
    ST_DECOD,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } estado_t;

  typedef enum logic [2:0] {
    CL_NENHUMA,
    CL_LD,
    CL_SD,
    CL_ADD,
    CL_SUB,
    CL_ADDI
  } classe_t;

endpackage

// File: rtl/decodificador_instrucao.sv
// Combinational decoder: splits an RV64 instruction into register fields,
// a sign-extended immediate and an instruction class, flagging anything
// outside the supported ld/sd/add/sub/addi subset as illegal.
module decodificador_instrucao
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instrucao,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imediato,
  output classe_t         classe,
  output logic            ilegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instrucao[6:0];
  assign rd     = instrucao[11:7];
  assign funct3 = instrucao[14:12];
  assign rs1    = instrucao[19:15];
  assign rs2    = instrucao[24:20];
  assign funct7 = instrucao[31:25];

  // Stores split the immediate around rd; every other class uses the I-type layout.
  always_comb begin
    if (opcode == OP_STORE)
      imediato = {{(XLEN-12){instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
    else
      imediato = {{(XLEN-12){instrucao[31]}}, instrucao[31:20]};
  end

  // Class lookup; anything not matched stays illegal.
  always_comb begin
    classe = CL_NENHUMA;
    ilegal = 1'b1;
    case (opcode)
      OP_LOAD:  if (funct3 == F3_DOUBLE) begin classe = CL_LD; ilegal = 1'b0; end
      OP_STORE: if (funct3 == F3_DOUBLE) begin classe = CL_SD; ilegal = 1'b0; end
      OP_REG: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) begin classe = CL_ADD; ilegal = 1'b0; end
        if (funct3 == F3_ADD && funct7 == F7_SUB) begin classe = CL_SUB; ilegal = 1'b0; end
      end
      OP_IMM:   if (funct3 == F3_ADD) begin classe = CL_ADDI; ilegal = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: sequences PC -> fetch -> IR -> decode -> execute
// (-> memory for loads) and drives every datapath enable and select.
// Handshake: none; start is a level sampled only in IDLE, all outputs are
// decoded from the current state and the fields registered during DECOD.
module unidade_controle
  import riscv_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int XLEN       = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     saida_IR,
  output logic            load_PC,
  output logic            load_IR,
  output logic            we,
  output logic            we_ram,
  output logic            we_mi,
  output logic [XLEN-1:0] PCres,
  output logic [4:0]      Ra,
  output logic [4:0]      Rb,
  output logic [4:0]      Rw,
  output logic [XLEN-1:0] entrada_mux_add_sub,
  output logic            decisor0,
  output logic            decisor1,
  output logic            decisor2,
  output logic            somador_subtrator,
  output logic            concluida,
  output logic            parado,
  output estado_t         estado
);

  estado_t         prox;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_prox;
  logic            primeira;

  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0] dec_imm;
  classe_t         dec_classe;
  logic            dec_ilegal;

  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0] imm_q;
  classe_t         classe_q;
  logic            rd_nz;

  decodificador_instrucao #(.XLEN(XLEN)) u_dec (
    .instrucao (saida_IR),
    .rd        (dec_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .imediato  (dec_imm),
    .classe    (dec_classe),
    .ilegal    (dec_ilegal)
  );

  // The very first fetch after reset targets word 0; afterwards step and wrap.
  assign pc_prox = primeira ? '0 :
                   (pc == XLEN'(IMEM_WORDS - 1)) ? '0 : pc + XLEN'(1);
  assign PCres   = (estado == ST_PC) ? pc_prox : pc;

  // Stores read the data register on Ra and the base on Rb.
  assign Ra    = (classe_q == CL_SD) ? rs2_q : rs1_q;
  assign Rb    = (classe_q == CL_SD) ? rs1_q : rs2_q;
  assign Rw    = rd_q;
  assign entrada_mux_add_sub = imm_q;
  assign we_mi = 1'b0;
  assign rd_nz = (rd_q != 5'd0);

  // State register, shadow PC and decoded-field capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= ST_IDLE;
      pc       <= '0;
      primeira <= 1'b1;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      classe_q <= CL_NENHUMA;
    end else begin
      estado <= prox;
      if (estado == ST_PC) begin
        pc       <= pc_prox;
        primeira <= 1'b0;
      end
      if (estado == ST_DECOD) begin
        rd_q     <= dec_rd;
        rs1_q    <= dec_rs1;
        rs2_q    <= dec_rs2;
        imm_q    <= dec_imm;
        classe_q <= dec_classe;
      end
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    prox              = estado;
    load_PC           = 1'b0;
    load_IR           = 1'b0;
    we                = 1'b0;
    we_ram            = 1'b0;
    decisor0          = 1'b0;
    decisor1          = 1'b0;
    decisor2          = 1'b0;
    somador_subtrator = 1'b0;
    concluida         = 1'b0;
    parado            = 1'b0;
    case (estado)
      ST_IDLE:  if (start) prox = ST_PC;
      ST_PC:    begin load_PC = 1'b1; prox = ST_BUSCA; end
      ST_BUSCA: prox = ST_IR;
      ST_IR:    begin load_IR = 1'b1; prox = ST_DECOD; end
      ST_DECOD: prox = dec_ilegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        prox = (classe_q == CL_LD) ? ST_MEM : ST_PC;
        case (classe_q)
          CL_ADD, CL_SUB: begin
            decisor1          = 1'b1;
            somador_subtrator = (classe_q == CL_SUB);
            we                = rd_nz;
            concluida         = 1'b1;
          end
          CL_ADDI: begin
            decisor0  = 1'b1;
            decisor1  = 1'b1;
            we        = rd_nz;
            concluida = 1'b1;
          end
          CL_LD: begin
            decisor0 = 1'b1;
            decisor1 = 1'b1;
            decisor2 = 1'b1;
          end
          CL_SD: begin
            decisor0  = 1'b1;
            we_ram    = 1'b1;
            concluida = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        prox      = ST_PC;
        decisor0  = 1'b1;
        decisor1  = 1'b1;
        decisor2  = 1'b1;
        we        = rd_nz;
        concluida = 1'b1;
      end
      ST_HALT:  parado = 1'b1;
      default:  prox = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: hand-written instruction table, random legal
// instructions checked against a field-level model, and reset/halt sequences.
module tb_unidade_controle;
  localparam int IMEM_WORDS = 32;
  localparam int XLEN       = 64;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [31:0]     saida_IR;
  logic            load_PC, load_IR, we, we_ram, we_mi;
  logic [XLEN-1:0] PCres, entrada_mux_add_sub;
  logic [4:0]      Ra, Rb, Rw;
  logic            decisor0, decisor1, decisor2, somador_subtrator, concluida, parado;
  riscv_pkg::estado_t estado;

  unidade_controle #(.IMEM_WORDS(IMEM_WORDS), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .saida_IR(saida_IR),
    .load_PC(load_PC), .load_IR(load_IR), .we(we), .we_ram(we_ram), .we_mi(we_mi),
    .PCres(PCres), .Ra(Ra), .Rb(Rb), .Rw(Rw), .entrada_mux_add_sub(entrada_mux_add_sub),
    .decisor0(decisor0), .decisor1(decisor1), .decisor2(decisor2),
    .somador_subtrator(somador_subtrator), .concluida(concluida), .parado(parado),
    .estado(estado)
  );

  // Clock and reset
  always #5 clk = ~clk;

  logic [9:0] ctl_now;
  assign ctl_now = {load_PC, load_IR, we, we_ram, decisor0, decisor1, decisor2,
                    somador_subtrator, concluida, parado};

  int n_checks = 0;
  int n_fail   = 0;
  int m_pc     = 0;
  bit m_first  = 1'b1;

  typedef struct {
    logic [31:0] ir;
    logic [4:0]  ra, rb, rw;
    logic [63:0] imm;
    bit          chk_rb, chk_rw, chk_imm, two_phase, illegal;
    logic [9:0]  ctl_exec, ctl_mem;
  } vec_t;

  function automatic logic [9:0] ctl(bit lp, bit li, bit w, bit wr, bit d0, bit d1,
                                     bit d2, bit ss, bit c, bit p);
    return {lp, li, w, wr, d0, d1, d2, ss, c, p};
  endfunction

  function automatic vec_t mk(logic [31:0] ir, logic [4:0] ra, logic [4:0] rb, logic [4:0] rw,
                              logic [63:0] imm, bit crb, bit crw, bit cimm, bit two, bit ill,
                              logic [9:0] ce, logic [9:0] cm);
    vec_t v;
    v.ir = ir; v.ra = ra; v.rb = rb; v.rw = rw; v.imm = imm;
    v.chk_rb = crb; v.chk_rw = crw; v.chk_imm = cimm; v.two_phase = two; v.illegal = ill;
    v.ctl_exec = ce; v.ctl_mem = cm;
    return v;
  endfunction

  // Reference model: build the encoding from the operation fields and derive
  // the expected execute behaviour from the operation's meaning.
  function automatic vec_t model(int kind, logic [4:0] rd, logic [4:0] rs1,
                                 logic [4:0] rs2, logic [11:0] imm12);
    vec_t v;
    logic signed [63:0] se;
    se = $signed(imm12);
    v.illegal = 1'b0; v.two_phase = (kind == 0);
    v.ra = rs1; v.rb = rs2; v.rw = rd; v.imm = se;
    v.chk_rb = 1'b0; v.chk_rw = 1'b1; v.chk_imm = 1'b0; v.ctl_mem = '0;
    case (kind)
      0: begin
        v.ir = {imm12, rs1, 3'b011, rd, 7'b0000011};
        v.chk_imm = 1'b1;
        v.ctl_exec = ctl(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        v.ctl_mem  = ctl(0, 0, rd != 0, 0, 1, 1, 1, 0, 1, 0);
      end
      1: begin
        v.ir = {imm12[11:5], rs2, rs1, 3'b011, imm12[4:0], 7'b0100011};
        v.ra = rs2; v.rb = rs1; v.chk_rb = 1'b1; v.chk_rw = 1'b0; v.chk_imm = 1'b1;
        v.ctl_exec = ctl(0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
      end
      2: begin
        v.ir = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
        v.chk_rb = 1'b1;
        v.ctl_exec = ctl(0, 0, rd != 0, 0, 0, 1, 0, 0, 1, 0);
      end
      3: begin
        v.ir = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
        v.chk_rb = 1'b1;
        v.ctl_exec = ctl(0, 0, rd != 0, 0, 0, 1, 0, 1, 1, 0);
      end
      default: begin
        v.ir = {imm12, rs1, 3'b000, rd, 7'b0010011};
        v.chk_imm = 1'b1;
        v.ctl_exec = ctl(0, 0, rd != 0, 0, 1, 1, 0, 0, 1, 0);
      end
    endcase
    return v;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'(ctl_now), 64'd0);
    chk({tag, "_pcres"}, PCres, 64'd0);
    chk({tag, "_regs"}, 64'({Ra, Rb, Rw}), 64'd0);
    chk({tag, "_imm"}, entrada_mux_add_sub, 64'd0);
    chk({tag, "_we_mi"}, 64'(we_mi), 64'd0);
  endtask

  // Driver: called at a negedge just before the cycle that enters PC.
  task automatic run_instr(input vec_t v);
    int exp_pc;
    saida_IR = v.ir;
    @(negedge clk);
    exp_pc = m_first ? 0 : (m_pc + 1) % IMEM_WORDS;
    chk("pc_ctl", 64'(ctl_now), 64'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("pc_pcres", PCres, 64'(exp_pc));
    m_pc = exp_pc; m_first = 1'b0;
    @(negedge clk);
    chk("busca_ctl", 64'(ctl_now), 64'd0);
    @(negedge clk);
    chk("ir_ctl", 64'(ctl_now), 64'(ctl(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    chk("decod_ctl", 64'(ctl_now), 64'd0);
    @(negedge clk);
    if (v.illegal) begin
      for (int i = 0; i < 5; i++) begin
        chk("halt_ctl", 64'(ctl_now), 64'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
        @(negedge clk);
      end
      return;
    end
    chk("exec_ctl", 64'(ctl_now), 64'(v.ctl_exec));
    chk("exec_ra", 64'(Ra), 64'(v.ra));
    if (v.chk_rb)  chk("exec_rb", 64'(Rb), 64'(v.rb));
    if (v.chk_rw)  chk("exec_rw", 64'(Rw), 64'(v.rw));
    if (v.chk_imm) chk("exec_imm", entrada_mux_add_sub, v.imm);
    chk("exec_we_mi", 64'(we_mi), 64'd0);
    if (v.two_phase) begin
      @(negedge clk);
      chk("mem_ctl", 64'(ctl_now), 64'(v.ctl_mem));
      chk("mem_ra", 64'(Ra), 64'(v.ra));
      chk("mem_rw", 64'(Rw), 64'(v.rw));
      chk("mem_imm", entrada_mux_add_sub, v.imm);
    end
  endtask

  vec_t tbl[6];

  initial begin
    // Expected values worked out by hand from the instruction encodings.
    tbl[0] = mk(32'h00410333, 5'd2, 5'd4, 5'd6, 64'd0, 1, 1, 0, 0, 0,
                ctl(0, 0, 1, 0, 0, 1, 0, 0, 1, 0), 10'd0);
    tbl[1] = mk(32'h403303B3, 5'd6, 5'd3, 5'd7, 64'd0, 1, 1, 0, 0, 0,
                ctl(0, 0, 1, 0, 0, 1, 0, 1, 1, 0), 10'd0);
    tbl[2] = mk(32'hFF618293, 5'd3, 5'd0, 5'd5, 64'hFFFFFFFFFFFFFFF6, 0, 1, 1, 0, 0,
                ctl(0, 0, 1, 0, 1, 1, 0, 0, 1, 0), 10'd0);
    tbl[3] = mk(32'h00803103, 5'd0, 5'd0, 5'd2, 64'd8, 0, 1, 1, 1, 0,
                ctl(0, 0, 0, 0, 1, 1, 1, 0, 0, 0), ctl(0, 0, 1, 0, 1, 1, 1, 0, 1, 0));
    tbl[4] = mk(32'h00713423, 5'd7, 5'd2, 5'd0, 64'd8, 1, 0, 1, 0, 0,
                ctl(0, 0, 0, 1, 1, 0, 0, 0, 1, 0), 10'd0);
    tbl[5] = mk(32'h00003003, 5'd0, 5'd0, 5'd0, 64'd0, 0, 1, 1, 1, 0,
                ctl(0, 0, 0, 0, 1, 1, 1, 0, 0, 0), ctl(0, 0, 0, 0, 1, 1, 1, 0, 1, 0));

    reset = 1'b1; start = 1'b0; saida_IR = 32'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_estado", 64'(estado), 64'(riscv_pkg::ST_IDLE));
    reset = 1'b0; start = 1'b1;   // start stays high for the rest of the run
    m_first = 1'b1; m_pc = 0;

    foreach (tbl[i]) run_instr(tbl[i]);

    // Random legal instructions; enough of them to wrap the PC past IMEM_WORDS-1.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v = model(int'($urandom_range(0, 4)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                12'($urandom_range(0, 4095)));
      run_instr(v);
    end

    // Reset in the middle of an add's execute cycle.
    saida_IR = 32'h00410333;
    repeat (5) @(negedge clk);
    chk("pre_reset_exec_we", 64'({we, concluida}), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_exec");
    reset = 1'b0;
    m_first = 1'b1; m_pc = 0;

    // Illegal encoding halts for good.
    run_instr(mk(32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 64'd0, 0, 0, 0, 0, 1, 10'd0, 10'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
